seq_restoring_divider: RTL and testbench

- Iterative radix-2 restoring unsigned divider; the inverse-direction companion to the team's multiplier and adder datapath.
- Accepts a dividend/divisor pair through a ready/start handshake.
- Produces one quotient bit per clock using a width+1-bit trial subtraction.
- Returns the quotient and remainder with a one-cycle done pulse.
- Used wherever a product must be scaled back, and as a golden-checkable partner for the multiplier benches.

---
 rtl/seq_restoring_divider.sv | 123 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock, start/ready handshake.
// Optional macro DIV_EARLY_EXIT_EN: requests with dividend < divisor complete on the accepting edge.
module seq_restoring_divider #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [width-1:0] dividend_i,
  input  logic [width-1:0] divisor_i,
  output logic             ready_o,
  output logic [width-1:0] quotient_o,
  output logic [width-1:0] remainder_o,
  output logic             done_o,
  output logic             div_by_zero_o
);

  localparam int cw = (width > 1) ? $clog2(width) : 1;
  localparam logic [cw-1:0] last_count = cw'(width - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_next;
  // The partial remainder always stays below the divisor, so its top bit is
  // never set between iterations and only width bits are stored.
  logic [width-1:0] rem, rem_next;
  logic [width-1:0] quo, quo_next;
  logic [width-1:0] dvs, dvs_next;
  logic [cw-1:0]    count, count_next;
  logic [width-1:0] quotient_next, remainder_next;
  logic             done_next, dbz_next;

  logic [width:0]   r_shift, trial;
  logic [width-1:0] r_iter, q_iter;
  logic             accept;

  always_comb begin
    r_shift = {rem, quo[width-1]};
    trial   = r_shift - {1'b0, dvs};
    r_iter  = trial[width] ? r_shift[width-1:0] : trial[width-1:0];
    q_iter  = {quo[width-2:0], ~trial[width]};
  end

  assign ready_o = (state == IDLE);
  assign accept  = start_i && (state == IDLE);

  always_comb begin
    state_next     = state;
    rem_next       = rem;
    quo_next       = quo;
    dvs_next       = dvs;
    count_next     = count;
    quotient_next  = quotient_o;
    remainder_next = remainder_o;
    dbz_next       = div_by_zero_o;
    done_next      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (divisor_i == '0) begin
            quotient_next  = '1;
            remainder_next = dividend_i;
            dbz_next       = 1'b1;
            done_next      = 1'b1;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (dividend_i < divisor_i) begin
            quotient_next  = '0;
            remainder_next = dividend_i;
            dbz_next       = 1'b0;
            done_next      = 1'b1;
          end
`endif
          else begin
            rem_next   = '0;
            quo_next   = dividend_i;
            dvs_next   = divisor_i;
            count_next = '0;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        rem_next   = r_iter;
        quo_next   = q_iter;
        count_next = count + 1'b1;
        if (count == last_count) begin
          quotient_next  = q_iter;
          remainder_next = r_iter;
          dbz_next       = 1'b0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      count         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      state         <= state_next;
      rem           <= rem_next;
      quo           <= quo_next;
      dvs           <= dvs_next;
      count         <= count_next;
      quotient_o    <= quotient_next;
      remainder_o   <= remainder_next;
      done_o        <= done_next;
      div_by_zero_o <= dbz_next;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed literal cases plus random traffic
// checked every cycle against an arithmetic reference model.
module tb_seq_restoring_divider;
  localparam int W = 8;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         ready_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         done_o;
  logic         div_by_zero_o;

  seq_restoring_divider #(.width(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .ready_o(ready_o), .quotient_o(quotient_o), .remainder_o(remainder_o),
    .done_o(done_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a request is busy for W edges after acceptance, results are plain / and %.
  int           ec = 0;
  bit           pend = 1'b0;
  int           pend_edge = 0;
  logic [W-1:0] p_q = '0, p_r = '0;
  logic [W-1:0] m_q = '0, m_r = '0;
  bit           m_dbz = 1'b0, m_done = 1'b0;
  bit           m_acc;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0; m_done = 1'b0;
    end else begin
      ec++;
      m_acc = start_i && !pend;
      m_a = dividend_i;
      m_b = divisor_i;
      m_done = 1'b0;
      if (pend && pend_edge == ec) begin
        m_q = p_q; m_r = p_r; m_dbz = 1'b0; m_done = 1'b1; pend = 1'b0;
      end
      if (m_acc) begin
        if (m_b == 0) begin
          m_q = '1; m_r = m_a; m_dbz = 1'b1; m_done = 1'b1;
        end else if (EARLY && m_a < m_b) begin
          m_q = '0; m_r = m_a; m_dbz = 1'b0; m_done = 1'b1;
        end else begin
          pend = 1'b1; pend_edge = ec + W; p_q = m_a / m_b; p_r = m_a % m_b;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("mdl_done", 32'(done_o), 32'(m_done));
    check("mdl_ready", 32'(ready_o), 32'(!pend));
    check("mdl_quot", 32'(quotient_o), 32'(m_q));
    check("mdl_rem", 32'(remainder_o), 32'(m_r));
    check("mdl_dbz", 32'(div_by_zero_o), 32'(m_dbz));
  end

  task automatic step();
    @(negedge clk_i);
    #2;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 20) begin
      step();
      n++;
    end
  endtask

  // Called two time units after a negedge with the DUT idle; returns in the done cycle.
  task automatic run_op(input string name, input int a, input int b, input int eq,
                        input int er, input int edbz, input int elat);
    int n;
    dividend_i = W'(a);
    divisor_i  = W'(b);
    start_i    = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(n);
    check({name, "_done"}, 32'(done_o), 1);
    check({name, "_lat"}, n, elat);
    check({name, "_q"}, 32'(quotient_o), eq);
    check({name, "_r"}, 32'(remainder_o), er);
    check({name, "_dbz"}, 32'(div_by_zero_o), edbz);
    check({name, "_ready"}, 32'(ready_o), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r;
    repeat (3) step();
    check("rst_ready", 32'(ready_o), 1);
    check("rst_done", 32'(done_o), 0);
    check("rst_q", 32'(quotient_o), 0);
    check("rst_r", 32'(remainder_o), 0);
    check("rst_dbz", 32'(div_by_zero_o), 0);
    rst_i = 1'b0;
    step();

    run_op("200/7", 200, 7, 28, 4, 0, 8);
    run_op("255/1", 255, 1, 255, 0, 0, 8);
    run_op("255/255", 255, 255, 1, 0, 0, 8);
    step();
    run_op("13/0", 13, 0, 255, 13, 1, 0);
    run_op("10/3", 10, 3, 3, 1, 0, 8);
    step();
    run_op("5/9", 5, 9, 0, 5, 0, EARLY ? 0 : 8);
    step();

    // A start during CALC must be ignored.
    dividend_i = 8'd100; divisor_i = 8'd6; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (2) step();
    dividend_i = 8'd50; divisor_i = 8'd5; start_i = 1'b1;
    step();
    start_i = 1'b0; dividend_i = 8'hA5; divisor_i = 8'h00;
    wait_done(n);
    check("ign_lat", n, 5);
    check("ign_q", 32'(quotient_o), 16);
    check("ign_r", 32'(remainder_o), 4);
    repeat (12) begin
      step();
      check("ign_extra_done", 32'(done_o), 0);
    end

    // Reset between edges 4 and 5 aborts the request.
    dividend_i = 8'd77; divisor_i = 8'd4; start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
    rst_i = 1'b1;
    #1;
    check("abort_ready", 32'(ready_o), 1);
    check("abort_done", 32'(done_o), 0);
    check("abort_q", 32'(quotient_o), 0);
    check("abort_r", 32'(remainder_o), 0);
    check("abort_dbz", 32'(div_by_zero_o), 0);
    step();
    rst_i = 1'b0;
    repeat (10) begin
      step();
      check("abort_no_done", 32'(done_o), 0);
    end
    run_op("77/4", 77, 4, 19, 1, 0, 8);
    step();

    repeat (3000) begin
      step();
      r = $urandom_range(0, 9);
      start_i = ($urandom_range(0, 2) == 0);
      dividend_i = (r < 3) ? W'($urandom_range(0, 20)) : W'($urandom);
      if (r == 0 || r == 9)
        divisor_i = '0;
      else if (r < 6)
        divisor_i = W'($urandom_range(1, 15));
      else
        divisor_i = W'($urandom);
      rst_i = ($urandom_range(0, 399) == 0);
    end
    step();
    start_i = 1'b0;
    rst_i = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
